rsa_cmd_ctrl: RTL
=================

// Module: rsa_cmd_ctrl
// PURPOSE
//  Parametrised Arm<->FPGA command controller for the modular-arithmetic datapath.
//  Decodes 32-bit Arm commands, loads operands into a slot register file and drives one external Montgomery/exponentiation core.
//  Adds start pulsing, compute timeout, error status and soft core reset.
//  Returns results over the TX_SIZE data port.
// PARAMETERS
//  TX_SIZE        1024  width of the Arm<->FPGA data buses
//  OPERAND_W      512   operand/result width; must be <= TX_SIZE
//  NUM_SLOTS      8     operand slots (power of 2, <= 8); slot index = cmd[10:8]
//  TIMEOUT_CYCLES 2**20 max cycles in COMPUTE before abort; 0 disables timeout
// PORTS
//  clk                     in   1                    rising-edge clock
//  resetn                  in   1                    async active-low reset
//  arm_to_fpga_cmd         in   32                   [3:0] opcode, [10:8] slot
//  arm_to_fpga_cmd_valid   in   1                    command present (sampled only in IDLE)
//  fpga_to_arm_done        out  1                    command complete, held until done_read
//  fpga_to_arm_done_read   in   1                    Arm acknowledges done
//  arm_to_fpga_data_valid  in   1                    inbound beat valid
//  arm_to_fpga_data_ready  out  1                    controller accepts inbound beat
//  arm_to_fpga_data        in   TX_SIZE              inbound beat
//  fpga_to_arm_data_valid  out  1                    outbound beat valid
//  fpga_to_arm_data_ready  in   1                    Arm accepts outbound beat
//  fpga_to_arm_data        out  TX_SIZE              outbound beat, zero-extended
//  core_resetn             out  1                    core reset, active-low
//  core_start              out  1                    one-cycle start pulse
//  core_mode               out  1                    0 = Montgomery product, 1 = exponentiation
//  core_operands           out  NUM_SLOTS*OPERAND_W  slot s at [s*OPERAND_W +: OPERAND_W]
//  core_done               in   1                    core result valid (single cycle or level)
//  core_result             in   OPERAND_W            core result
//  leds                    out  4                    {err_flag, state[2:0]}
// BEHAVIOUR
//  Reset (async, resetn=0):
//   state=IDLE; slots, result_reg, status=0; core_resetn=0
//   all other outputs 0
//   core_resetn rises the first clk after resetn deasserts.
//  States: IDLE(0) LOAD(1) COMPUTE(2) WRITE(3) DONE(4).
//  Opcodes in IDLE with cmd_valid:
//   0x1 LOAD          -> LOAD
//   0x2 COMPUTE_MONT  -> COMPUTE, mode 0
//   0x3 COMPUTE_EXP   -> COMPUTE, mode 1
//   0x4 WRITE_RESULT  -> WRITE
//   0x5 SOFT_RESET    -> core_resetn=0 for exactly 1 cycle, status cleared -> DONE
//   0x6 READ_STATUS   -> WRITE, data = {zeros, status[7:0]}
//   0x7 READ_CYCLES   -> see CONFIGURATION
//   other opcodes     -> status[0] (ILLEGAL_CMD) set -> DONE
//  LOAD:
//   data_ready=1 while in LOAD.
//   Beat transfers when valid&&ready on a clk edge: slot[cmd[10:8] mod NUM_SLOTS] <= data[OPERAND_W-1:0]; -> DONE.
//   Upper bits ignored.
//  COMPUTE:
//   core_start=1 only in the first cycle after entry; core_mode registered at entry, stable for the whole state.
//   On core_done: result_reg <= core_result -> DONE. Latency to DONE = 1 cycle after core_done.
//   Timeout: if TIMEOUT_CYCLES!=0 and cycle count reaches it, set status[1] (TIMEOUT), pulse core_resetn low 1 cycle, result_reg unchanged -> DONE.
//   core_done in the same cycle as timeout: done wins, no error.
//  WRITE:
//   data_valid=1 with fpga_to_arm_data stable. Leaves to DONE on the edge where ready=1.
//   ready already high on entry: one-cycle handshake.
//  DONE:
//   fpga_to_arm_done=1 registered, so it rises 1 cycle after entering DONE.
//   done_read=1 -> IDLE; done falls the next cycle.
//  cmd_valid outside IDLE is ignored (no queueing).
//  status[2] (BUSY) mirrors state!=IDLE when read. status bits sticky until SOFT_RESET or resetn.
//  core_operands driven directly from slot registers.
// CONFIGURATION
//  RSA_CYCLE_COUNT_EN defined:
//   32-bit counter clears on entering COMPUTE, increments each COMPUTE cycle, holds value after exit.
//   READ_CYCLES -> WRITE with data = {zeros, count}.
//  RSA_CYCLE_COUNT_EN undefined:
//   no counter logic; READ_CYCLES treated as illegal (status[0] set -> DONE).
// TESTING
//  T1 resetn=0 mid-COMPUTE -> immediately state=IDLE, done=0, core_resetn=0, core_start=0; READ_STATUS afterwards returns 0.
//  T2 LOAD slot 3 with 0xA5..A5, then COMPUTE_MONT -> core_operands[3*OPERAND_W+:OPERAND_W]=0xA5..A5, exactly one core_start pulse.
//     Core returns 0x1234 after 10 cycles -> done rises, WRITE_RESULT data=0x1234.
//  T3 Opcode 0xF -> done asserted, no data handshake; READ_STATUS returns 0x05 while in WRITE (ILLEGAL + BUSY); SOFT_RESET -> status 0.
//  T4 TIMEOUT_CYCLES=16, core never finishes -> done after 16 COMPUTE cycles, status[1]=1, one-cycle core_resetn low, result_reg unchanged.
//  T5 WRITE with fpga_to_arm_data_ready held low 50 cycles -> data_valid stays 1 with data stable; ready=1 -> DONE next cycle.
//  T6 RSA_CYCLE_COUNT_EN set, core done at compute cycle 100 -> READ_CYCLES returns 100.
//     Macro unset -> READ_CYCLES sets ILLEGAL.

Source files
------------

// File: rtl/rsa_cmd_ctrl.sv
// Arm<->FPGA command controller: decodes Arm commands, fills operand slots, runs one external modexp/Montgomery core.
// Latency: command accepted 1 cycle after cmd_valid in IDLE; DONE is entered 1 cycle after core_done, a data handshake or a decode.
// Backpressure: one command in flight, cmd_valid outside IDLE is dropped; WRITE holds data_valid and data until the Arm raises ready.
//
// Ports:
//   clk, resetn                    clock, async active-low reset
//   arm_to_fpga_cmd[_valid]        [3:0] opcode, [10:8] slot index
//   fpga_to_arm_done[_read]        completion flag and its acknowledge
//   arm_to_fpga_data*              inbound operand beat (valid/ready)
//   fpga_to_arm_data*              outbound result beat (valid/ready), zero-extended
//   core_*                         reset, start pulse, mode, slot operands, done/result of the core
//   leds                           {err_flag, state[2:0]}
// Optional build macro: RSA_CYCLE_COUNT_EN adds a 32-bit COMPUTE cycle counter readable via READ_CYCLES.

module rsa_cmd_ctrl #(
    parameter int TX_SIZE        = 1024,
    parameter int OPERAND_W      = 512,
    parameter int NUM_SLOTS      = 8,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [31:0]                    arm_to_fpga_cmd,
    input  logic                           arm_to_fpga_cmd_valid,
    output logic                           fpga_to_arm_done,
    input  logic                           fpga_to_arm_done_read,
    input  logic                           arm_to_fpga_data_valid,
    output logic                           arm_to_fpga_data_ready,
    input  logic [TX_SIZE-1:0]             arm_to_fpga_data,
    output logic                           fpga_to_arm_data_valid,
    input  logic                           fpga_to_arm_data_ready,
    output logic [TX_SIZE-1:0]             fpga_to_arm_data,
    output logic                           core_resetn,
    output logic                           core_start,
    output logic                           core_mode,
    output logic [NUM_SLOTS*OPERAND_W-1:0] core_operands,
    input  logic                           core_done,
    input  logic [OPERAND_W-1:0]           core_result,
    output logic [3:0]                     leds
);

    localparam int              TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit              TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    // NUM_SLOTS is a power of two, so masking the slot field is the modulo.
    localparam logic [2:0]      SLOT_MASK = 3'(NUM_SLOTS - 1);

    localparam logic [3:0] OP_LOAD         = 4'h1;
    localparam logic [3:0] OP_COMPUTE_MONT = 4'h2;
    localparam logic [3:0] OP_COMPUTE_EXP  = 4'h3;
    localparam logic [3:0] OP_WRITE_RESULT = 4'h4;
    localparam logic [3:0] OP_SOFT_RESET   = 4'h5;
    localparam logic [3:0] OP_READ_STATUS  = 4'h6;
`ifdef RSA_CYCLE_COUNT_EN
    localparam logic [3:0] OP_READ_CYCLES  = 4'h7;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    state_e                         state_q,       state_d;
    logic [2:0]                     slot_sel_q,    slot_sel_d;
    logic [NUM_SLOTS*OPERAND_W-1:0] slots_q,       slots_d;
    logic [OPERAND_W-1:0]           result_q,      result_d;
    logic [1:0]                     status_q,      status_d;    // [1] TIMEOUT, [0] ILLEGAL_CMD
    logic                           core_resetn_q, core_resetn_d;
    logic                           core_start_q,  core_start_d;
    logic                           core_mode_q,   core_mode_d;
    logic                           done_q,        done_d;
    logic                           in_rdy_q,      in_rdy_d;
    logic                           out_vld_q,     out_vld_d;
    logic [TX_SIZE-1:0]             out_dat_q,     out_dat_d;
    logic [TMO_W-1:0]               tmo_cnt_q,     tmo_cnt_d;
`ifdef RSA_CYCLE_COUNT_EN
    logic [31:0]                    cyc_cnt_q,     cyc_cnt_d;
`endif

    logic [3:0] opcode;
    assign opcode = arm_to_fpga_cmd[3:0];

    always_comb begin
        state_d       = state_q;
        slot_sel_d    = slot_sel_q;
        slots_d       = slots_q;
        result_d      = result_q;
        status_d      = status_q;
        core_resetn_d = 1'b1;           // low pulses last exactly one cycle
        core_start_d  = 1'b0;           // start is a single-cycle pulse
        core_mode_d   = core_mode_q;
        done_d        = done_q;
        in_rdy_d      = in_rdy_q;
        out_vld_d     = out_vld_q;
        out_dat_d     = out_dat_q;
        tmo_cnt_d     = tmo_cnt_q;
`ifdef RSA_CYCLE_COUNT_EN
        cyc_cnt_d     = cyc_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    if (opcode == OP_LOAD) begin
                        slot_sel_d = arm_to_fpga_cmd[10:8] & SLOT_MASK;
                        in_rdy_d   = 1'b1;
                        state_d    = ST_LOAD;
                    end else if (opcode == OP_COMPUTE_MONT || opcode == OP_COMPUTE_EXP) begin
                        core_mode_d  = (opcode == OP_COMPUTE_EXP);
                        core_start_d = 1'b1;
                        tmo_cnt_d    = '0;
`ifdef RSA_CYCLE_COUNT_EN
                        cyc_cnt_d    = '0;
`endif
                        state_d      = ST_COMPUTE;
                    end else if (opcode == OP_WRITE_RESULT) begin
                        out_dat_d                = '0;
                        out_dat_d[OPERAND_W-1:0] = result_q;
                        out_vld_d                = 1'b1;
                        state_d                  = ST_WRITE;
                    end else if (opcode == OP_SOFT_RESET) begin
                        core_resetn_d = 1'b0;
                        status_d      = '0;
                        state_d       = ST_DONE;
                    end else if (opcode == OP_READ_STATUS) begin
                        // The value is presented while in WRITE, so BUSY always reads 1.
                        out_dat_d      = '0;
                        out_dat_d[7:0] = {5'b0, 1'b1, status_q};
                        out_vld_d      = 1'b1;
                        state_d        = ST_WRITE;
`ifdef RSA_CYCLE_COUNT_EN
                    end else if (opcode == OP_READ_CYCLES) begin
                        out_dat_d       = '0;
                        out_dat_d[31:0] = cyc_cnt_q;
                        out_vld_d       = 1'b1;
                        state_d         = ST_WRITE;
`endif
                    end else begin
                        status_d[0] = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_LOAD: begin
                if (arm_to_fpga_data_valid && in_rdy_q) begin
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        if (slot_sel_q == 3'(s)) begin
                            slots_d[s*OPERAND_W +: OPERAND_W] = arm_to_fpga_data[OPERAND_W-1:0];
                        end
                    end
                    in_rdy_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end

            ST_COMPUTE: begin
`ifdef RSA_CYCLE_COUNT_EN
                cyc_cnt_d = cyc_cnt_q + 32'd1;
`endif
                // core_done is checked first so a result on the timeout cycle is kept.
                if (core_done) begin
                    result_d = core_result;
                    state_d  = ST_DONE;
                end else if (TMO_EN && tmo_cnt_q == TMO_LAST) begin
                    status_d[1]   = 1'b1;
                    core_resetn_d = 1'b0;
                    state_d       = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            ST_WRITE: begin
                if (fpga_to_arm_data_ready) begin
                    out_vld_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                // Only an acknowledge of a visible done completes the command.
                if (done_q && fpga_to_arm_done_read) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            slot_sel_q    <= '0;
            slots_q       <= '0;
            result_q      <= '0;
            status_q      <= '0;
            core_resetn_q <= 1'b0;
            core_start_q  <= 1'b0;
            core_mode_q   <= 1'b0;
            done_q        <= 1'b0;
            in_rdy_q      <= 1'b0;
            out_vld_q     <= 1'b0;
            out_dat_q     <= '0;
            tmo_cnt_q     <= '0;
`ifdef RSA_CYCLE_COUNT_EN
            cyc_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            slot_sel_q    <= slot_sel_d;
            slots_q       <= slots_d;
            result_q      <= result_d;
            status_q      <= status_d;
            core_resetn_q <= core_resetn_d;
            core_start_q  <= core_start_d;
            core_mode_q   <= core_mode_d;
            done_q        <= done_d;
            in_rdy_q      <= in_rdy_d;
            out_vld_q     <= out_vld_d;
            out_dat_q     <= out_dat_d;
            tmo_cnt_q     <= tmo_cnt_d;
`ifdef RSA_CYCLE_COUNT_EN
            cyc_cnt_q     <= cyc_cnt_d;
`endif
        end
    end

    assign fpga_to_arm_done       = done_q;
    assign arm_to_fpga_data_ready = in_rdy_q;
    assign fpga_to_arm_data_valid = out_vld_q;
    assign fpga_to_arm_data       = out_dat_q;
    assign core_resetn            = core_resetn_q;
    assign core_start             = core_start_q;
    assign core_mode              = core_mode_q;
    assign core_operands          = slots_q;
    assign leds                   = {|status_q, state_q};

    // Command fields and inbound bits above the operand width carry no meaning.
    logic unused_cmd;
    assign unused_cmd = ^{arm_to_fpga_cmd[31:11], arm_to_fpga_cmd[7:4]};

    if (TX_SIZE > OPERAND_W) begin : g_unused_hi
        logic unused_data_hi;
        assign unused_data_hi = ^arm_to_fpga_data[TX_SIZE-1:OPERAND_W];
    end

endmodule
